segre_mem_arbiter: RTL and testbench

- Shares the single main-memory line port between the instruction cache and the data cache.
- Sequences each data-cache miss as an atomic pair: dirty-line writeback first, then line fill.
- Alternates fairly between the two caches when both are waiting, and returns filled lines to the cache that requested them.
- Sits between segre_cache instances (ICACHE/DCACHE) and the memory model, replacing the direct cache-to-memory wiring.

---
 rtl/segre_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_segre_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_mem_arbiter.sv
// ============================================================================
// segre_mem_arbiter - shares the main-memory line port between icache/dcache
// Rev 1.0
// ============================================================================
`default_nettype none

module segre_mem_arbiter #(
  parameter int WORD_SIZE             = 32,
  parameter int CACHE_LINE_SIZE_BYTES = 16,
  parameter int OFFSET_BITS           = $clog2(CACHE_LINE_SIZE_BYTES)
) (
  input  logic                               clk_i,
  input  logic                               rsn_i,
  input  logic                               ic_rd_req_i,
  input  logic [WORD_SIZE-1:0]               ic_addr_i,
  output logic                               ic_valid_o,
  output logic [CACHE_LINE_SIZE_BYTES*8-1:0] ic_line_o,
  input  logic                               dc_rd_req_i,
  input  logic                               dc_wr_req_i,
  input  logic [WORD_SIZE-1:0]               dc_addr_i,
  input  logic [WORD_SIZE-1:0]               dc_wb_addr_i,
  input  logic [CACHE_LINE_SIZE_BYTES*8-1:0] dc_wb_line_i,
  output logic                               dc_wb_done_o,
  output logic                               dc_valid_o,
  output logic [CACHE_LINE_SIZE_BYTES*8-1:0] dc_line_o,
  output logic                               mem_rd_o,
  output logic                               mem_wr_o,
  output logic [WORD_SIZE-1:0]               mem_addr_o,
  output logic [CACHE_LINE_SIZE_BYTES*8-1:0] mem_wr_line_o,
  input  logic [CACHE_LINE_SIZE_BYTES*8-1:0] mem_line_i,
  input  logic                               mem_ready_i,
  output logic                               arb_busy_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DC_WB = 3'd1,
    DC_RD = 3'd2,
    IC_RD = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t               state;
  logic                 last_dc;
  logic                 rd_pending;
  logic [WORD_SIZE-1:0] rd_addr;
  logic                 dc_req;
  logic                 grant_dc;

  function automatic logic [WORD_SIZE-1:0] align(input logic [WORD_SIZE-1:0] a);
    logic [WORD_SIZE-1:0] r;
    r = a;
    r[OFFSET_BITS-1:0] = '0;
    return r;
  endfunction

  assign dc_req   = dc_rd_req_i | dc_wr_req_i;
  // On a tie, last_dc decides; a lone dcache request always wins.
  assign grant_dc = dc_req & (~ic_rd_req_i | ~last_dc);

  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      state         <= IDLE;
      last_dc       <= 1'b0;
      rd_pending    <= 1'b0;
      rd_addr       <= '0;
      ic_valid_o    <= 1'b0;
      ic_line_o     <= '0;
      dc_wb_done_o  <= 1'b0;
      dc_valid_o    <= 1'b0;
      dc_line_o     <= '0;
      mem_rd_o      <= 1'b0;
      mem_wr_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wr_line_o <= '0;
      arb_busy_o    <= 1'b0;
    end else begin
      ic_valid_o   <= 1'b0;
      dc_valid_o   <= 1'b0;
      dc_wb_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (dc_req || ic_rd_req_i) begin
            arb_busy_o <= 1'b1;
            if (grant_dc) begin
              last_dc    <= 1'b1;
              rd_pending <= dc_rd_req_i;
              rd_addr    <= align(dc_addr_i);
              if (dc_wr_req_i) begin
                state         <= DC_WB;
                mem_wr_o      <= 1'b1;
                mem_addr_o    <= align(dc_wb_addr_i);
                mem_wr_line_o <= dc_wb_line_i;
              end else begin
                state      <= DC_RD;
                mem_rd_o   <= 1'b1;
                mem_addr_o <= align(dc_addr_i);
              end
            end else begin
              last_dc    <= 1'b0;
              state      <= IC_RD;
              mem_rd_o   <= 1'b1;
              mem_addr_o <= align(ic_addr_i);
            end
          end
        end
        DC_WB: begin
          if (mem_ready_i) begin
            mem_wr_o     <= 1'b0;
            dc_wb_done_o <= 1'b1;
            // The fill follows the writeback directly, keeping the pair atomic.
            if (rd_pending) begin
              state      <= DC_RD;
              mem_rd_o   <= 1'b1;
              mem_addr_o <= rd_addr;
            end else begin
              state      <= IDLE;
              arb_busy_o <= 1'b0;
            end
          end
        end
        DC_RD: begin
          if (mem_ready_i) begin
            mem_rd_o   <= 1'b0;
            dc_line_o  <= mem_line_i;
            dc_valid_o <= 1'b1;
            state      <= RESP;
          end
        end
        IC_RD: begin
          if (mem_ready_i) begin
            mem_rd_o   <= 1'b0;
            ic_line_o  <= mem_line_i;
            ic_valid_o <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          state      <= IDLE;
          arb_busy_o <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          arb_busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_segre_mem_arbiter.sv
// ============================================================================
// tb_segre_mem_arbiter - scoreboard bench with a latency-programmable memory
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_segre_mem_arbiter;

  localparam int K_RD = 0, K_WR = 1, K_DONE = 2, K_IC = 3, K_DC = 4;

  typedef struct {
    int           kind;
    logic [31:0]  addr;
    logic [127:0] line;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_rd_req, dc_rd_req, dc_wr_req;
  logic [31:0]  ic_addr, dc_addr, dc_wb_addr;
  logic [127:0] dc_wb_line;
  logic         ic_valid, dc_wb_done, dc_valid;
  logic [127:0] ic_line, dc_line;
  logic         mem_rd, mem_wr, mem_ready;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wr_line, mem_line;
  logic         arb_busy;

  int  checks = 0;
  int  failures = 0;
  int  lat = 3;
  bit  mem_enable = 1'b1;
  bit  inject_ready = 1'b0;
  ev_t exp_q[$];

  segre_mem_arbiter dut (
    .clk_i         (clk),
    .rsn_i         (rst),
    .ic_rd_req_i   (ic_rd_req),
    .ic_addr_i     (ic_addr),
    .ic_valid_o    (ic_valid),
    .ic_line_o     (ic_line),
    .dc_rd_req_i   (dc_rd_req),
    .dc_wr_req_i   (dc_wr_req),
    .dc_addr_i     (dc_addr),
    .dc_wb_addr_i  (dc_wb_addr),
    .dc_wb_line_i  (dc_wb_line),
    .dc_wb_done_o  (dc_wb_done),
    .dc_valid_o    (dc_valid),
    .dc_line_o     (dc_line),
    .mem_rd_o      (mem_rd),
    .mem_wr_o      (mem_wr),
    .mem_addr_o    (mem_addr),
    .mem_wr_line_o (mem_wr_line),
    .mem_line_i    (mem_line),
    .mem_ready_i   (mem_ready),
    .arb_busy_o    (arb_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a + 32'h1111_1111, ~a, a ^ 32'h0F0F_F0F0};
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] addr, input logic [127:0] line);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.line = line;
    exp_q.push_back(e);
  endtask

  task automatic expect_ev(input int kind, input logic [31:0] addr, input logic [127:0] line);
    ev_t e;
    check_eq($sformatf("event_expected_k%0d", kind), exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq("event_kind", kind, e.kind);
      if (kind == K_RD || kind == K_WR) check_eq($sformatf("cmd_addr_k%0d", kind), addr, e.addr);
      if (kind == K_WR || kind == K_IC || kind == K_DC) check_eq($sformatf("line_k%0d", kind), line, e.line);
    end
  endtask

  task automatic wait_pulse(input int which, input int budget, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk);
      #1;
      case (which)
        0: found = ic_valid;
        1: found = dc_valid;
        2: found = dc_wb_done;
        3: found = mem_rd;
        default: found = 1'b0;
      endcase
    end
    check_eq({tag, "_seen"}, found, 1);
  endtask

  // Memory model: answers each command after 'lat' cycles.
  initial begin
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    mem_line  = '0;
    forever begin
      @(negedge clk);
      mem_ready = inject_ready;
      if (mem_enable && (mem_rd || mem_wr) && !rst) begin
        if (cnt >= lat - 1) begin
          mem_ready = 1'b1;
          mem_line  = line_of(mem_addr);
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: every response pulse and every new memory command pops the scoreboard.
  initial begin
    bit          cmd_prev, cmd_now, rdy;
    logic [31:0] held;
    cmd_prev = 1'b0;
    held = '0;
    forever begin
      @(posedge clk);
      rdy = mem_ready;
      #1;
      cmd_now = mem_rd | mem_wr;
      if (dc_wb_done) expect_ev(K_DONE, '0, '0);
      if (ic_valid)   expect_ev(K_IC, '0, ic_line);
      if (dc_valid)   expect_ev(K_DC, '0, dc_line);
      if (cmd_now) begin
        check_eq("rd_wr_exclusive", mem_rd & mem_wr, 0);
        if (!cmd_prev || rdy) begin
          expect_ev(mem_wr ? K_WR : K_RD, mem_addr, mem_wr_line);
          held = mem_addr;
        end else begin
          check_eq("cmd_addr_stable", mem_addr, held);
        end
      end
      cmd_prev = cmd_now;
    end
  end

  initial begin
    int nd, ni;
    bit done;
    rst = 1'b1;
    ic_rd_req = 0; dc_rd_req = 0; dc_wr_req = 0;
    ic_addr = '0; dc_addr = '0; dc_wb_addr = '0; dc_wb_line = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_pulses", {ic_valid, dc_valid, dc_wb_done}, 0);
    check_eq("rst_cmds", {mem_rd, mem_wr, arb_busy}, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_lines", ic_line | dc_line | mem_wr_line, 0);
    rst = 1'b0;

    // Icache-only fill
    lat = 3;
    push(K_RD, 32'h0000_1230, '0);
    push(K_IC, '0, line_of(32'h0000_1230));
    ic_addr = 32'h0000_1234; ic_rd_req = 1;
    wait_pulse(0, 20, "ic_only");
    ic_rd_req = 0;
    check_eq("ic_only_dc_line", dc_line, 0);
    repeat (2) @(posedge clk);

    // Dirty dcache miss: writeback then fill
    lat = 2;
    dc_wb_line = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    push(K_WR, 32'h200, dc_wb_line);
    push(K_DONE, '0, '0);
    push(K_RD, 32'h400, '0);
    push(K_DC, '0, line_of(32'h400));
    dc_wb_addr = 32'h200; dc_addr = 32'h404; dc_wr_req = 1; dc_rd_req = 1;
    wait_pulse(2, 20, "dirty_done");
    check_eq("dirty_rd_follows", {mem_rd, mem_wr}, 2'b10);
    check_eq("dirty_rd_addr", mem_addr, 32'h400);
    wait_pulse(1, 20, "dirty_fill");
    dc_wr_req = 0; dc_rd_req = 0;
    repeat (2) @(posedge clk);

    // Writeback only
    lat = 1;
    dc_wb_line = 128'hA5A5_0000_1111_2222_3333_4444_5555_5A5A;
    push(K_WR, 32'h300, dc_wb_line);
    push(K_DONE, '0, '0);
    dc_wb_addr = 32'h30C; dc_wr_req = 1;
    wait_pulse(2, 20, "wb_only");
    dc_wr_req = 0;
    check_eq("wb_only_idle", arb_busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("wb_only_no_fill_q", exp_q.size(), 0);

    // Fairness after reset: D, I, D, I
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    lat = 2;
    push(K_RD, 32'h2000, '0); push(K_DC, '0, line_of(32'h2000));
    push(K_RD, 32'h1000, '0); push(K_IC, '0, line_of(32'h1000));
    push(K_RD, 32'h2040, '0); push(K_DC, '0, line_of(32'h2040));
    push(K_RD, 32'h1040, '0); push(K_IC, '0, line_of(32'h1040));
    dc_addr = 32'h2000; ic_addr = 32'h1000; dc_rd_req = 1; ic_rd_req = 1;
    nd = 0; ni = 0; done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #1;
      if (dc_valid) begin nd++; dc_addr += 32'h40; end
      if (ic_valid) begin ni++; ic_addr += 32'h40; end
      if (nd == 2 && ni == 2) begin
        dc_rd_req = 0; ic_rd_req = 0; done = 1;
      end
    end
    check_eq("fair_complete", done, 1);
    repeat (3) @(posedge clk);

    // Reset in the middle of a dcache fill
    mem_enable = 0;
    push(K_RD, 32'h600, '0);
    dc_addr = 32'h600; dc_rd_req = 1;
    wait_pulse(3, 10, "abort_cmd");
    dc_rd_req = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("abort_rd_dropped", mem_rd, 0);
    check_eq("abort_busy", arb_busy, 0);
    rst = 1'b0;
    inject_ready = 1;
    @(negedge clk);
    @(negedge clk);
    inject_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("abort_no_valid", dc_valid, 0);
    end
    mem_enable = 1;
    lat = 2;
    push(K_RD, 32'h700, '0); push(K_DC, '0, line_of(32'h700));
    push(K_RD, 32'h800, '0); push(K_IC, '0, line_of(32'h800));
    dc_addr = 32'h700; ic_addr = 32'h800; dc_rd_req = 1; ic_rd_req = 1;
    wait_pulse(1, 20, "tie_after_abort_dc");
    dc_rd_req = 0;
    wait_pulse(0, 20, "tie_after_abort_ic");
    ic_rd_req = 0;
    repeat (2) @(posedge clk);

    // Icache requester withdraws right after the grant
    lat = 4;
    push(K_RD, 32'h1500, '0); push(K_IC, '0, line_of(32'h1500));
    ic_addr = 32'h1508; ic_rd_req = 1;
    wait_pulse(3, 10, "withdraw_cmd");
    ic_rd_req = 0;
    wait_pulse(0, 20, "withdraw_valid");

    repeat (6) @(posedge clk);
    #1;
    check_eq("final_idle", arb_busy, 0);
    check_eq("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
